vmvmb_seq: RTL and testbench
============================

# vmvmb_seq

Sequential scheduler that computes the LSTM gate pre-activation A = Wx·x + Wh·h_prev + b one output element at a time over a single shared dual-product MAC lane, instead of the fully parallel combinational path. It generates read addresses for externally held x, h_prev, b, Wx and Wh memories (synchronous, 1-cycle read latency) and emits each A[j] through a valid/ready stream. It sits between the gate-weight storage and the activation stage.

## Interface
- N_IN, 100, length of x / h_prev; row count of Wx, Wh
- N_OUT, 400, length of b / A; column count of Wx, Wh
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse after the final A element handshakes
- rd_en  out  1  address outputs valid this cycle
- row_addr  out  $clog2(N_IN)  index i for x, h_prev, Wx[i][*], Wh[i][*]
- col_addr  out  $clog2(N_OUT)  index j for b, Wx[*][j], Wh[*][j]
- x_data, h_data, wx_data, wh_data, b_data  in  32 each  signed read data, valid one cycle after rd_en
- a_valid  out  1  A element available
- a_ready  in  1  downstream accepts
- a_idx  out  $clog2(N_OUT)  index j of a_data
- a_data  out  32  signed A[j]

## Operation
- States: IDLE, ACCUM, DRAIN, WRITE, DONE.
- IDLE: start=1 → ACCUM, j=0, i=0.
- ACCUM: rd_en=1, row_addr=i, col_addr=j; i increments each cycle; after issuing i=N_IN-1 → DRAIN.
- Accumulate on the cycle read data returns: first beat acc = b_data + wx_data·x_data + wh_data·h_data; later beats acc += wx_data·x_data + wh_data·h_data. b_data is sampled only on the first beat.
- DRAIN: rd_en=0; absorbs the last returning beat → WRITE.
- WRITE: a_valid=1, a_idx=j, a_data=acc, held stable until a_ready. On handshake: if j=N_OUT-1 → DONE, else j++, i=0 → ACCUM.
- DONE: done=1 for one cycle → IDLE.
- Arithmetic: 32-bit signed two's complement; each product truncated to its low 32 bits; all sums wrap modulo 2^32, no saturation.
- start while not IDLE is ignored.
- rst at any time: state IDLE, i=j=0, acc=0; pass aborted, no done pulse.

## Timing
- Reset values: busy=0, done=0, rd_en=0, row_addr=0, col_addr=0, a_valid=0, a_idx=0, a_data=0.
- Start sampled in cycle 0; first address issued in cycle 1; first a_valid in cycle N_IN+2.
- With a_ready held high: one element per N_IN+2 cycles; done asserted in cycle N_OUT·(N_IN+2)+1.
- Each cycle of a_ready=0 in WRITE adds exactly one cycle; addresses are not issued while stalled.
- a_valid is never deasserted without a handshake, except by rst.

## Structure
- Package vmvmb_pkg: N_IN/N_OUT defaults, DATA_W=32, state enum type.
- Sub-module vmvmb_mac: dual multiply plus accumulate with first-beat bias load; 32-bit wrap.
- Controller FSM, counters and output register in vmvmb_seq.

## Test plan
- N_IN=2, N_OUT=1, x={1,2}, h={3,4}, Wx col={5,6}, Wh col={7,8}, b=10, a_ready=1 → a_data=5+12+21+32+10=80 at cycle 4; done at cycle 5.
- N_IN=4, N_OUT=3, random data, a_ready=1 → a_idx 0,1,2 at cycles 6,12,18; each matches the reference model; done at cycle 19.
- Same setup, a_ready low for 3 cycles on j=1 → a_data/a_idx stable while stalled; no address during stall; done at cycle 22.
- Overflow: wx=32'h4000_0000, x=4, others 0, b=1 → a_data=1 (product wraps to 0).
- rst asserted in ACCUM of j=1 → all outputs return to reset values next cycle; no done; a new start produces a correct full pass.
- start pulsed while busy → ignored; element count and done timing are unchanged.

Source files
------------

// File: rtl/vmvmb_pkg.sv
// Shared types and defaults for the sequential LSTM gate pre-activation scheduler.
package vmvmb_pkg;

  localparam int unsigned N_IN_DEF  = 100;
  localparam int unsigned N_OUT_DEF = 400;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDrain,
    StWrite,
    StDone
  } state_e;

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vmvmb_mac.sv
// Dual-product MAC lane: acc = (first ? b : acc) + wx*x + wh*h, all wrapping at DATA_W bits.
module vmvmb_mac
  import vmvmb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     beat_i,
  input  logic                     first_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] h_i,
  input  logic signed [DATA_W-1:0] wx_i,
  input  logic signed [DATA_W-1:0] wh_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] acc_o
);

  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] prod_x, prod_h, base;

  always_comb begin
    // Products are evaluated in a DATA_W-wide context, keeping only the low bits.
    prod_x = wx_i * x_i;
    prod_h = wh_i * h_i;
    base   = first_i ? b_i : acc_q;
    acc_d  = acc_q;
    if (beat_i) begin
      acc_d = base + prod_x + prod_h;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/vmvmb_seq.sv
// Sequential scheduler: walks i over N_IN for each output j, feeding one shared MAC lane,
// and streams each finished A[j] through a valid/ready handshake.
module vmvmb_seq
  import vmvmb_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned N_OUT = N_OUT_DEF,
  localparam int unsigned RowW = addr_w(N_IN),
  localparam int unsigned ColW = addr_w(N_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [RowW-1:0]          row_addr,
  output logic [ColW-1:0]          col_addr,
  input  logic signed [DATA_W-1:0] x_data,
  input  logic signed [DATA_W-1:0] h_data,
  input  logic signed [DATA_W-1:0] wx_data,
  input  logic signed [DATA_W-1:0] wh_data,
  input  logic signed [DATA_W-1:0] b_data,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [ColW-1:0]          a_idx,
  output logic signed [DATA_W-1:0] a_data
);

  localparam logic [RowW-1:0] IMax = RowW'(N_IN - 1);
  localparam logic [ColW-1:0] JMax = ColW'(N_OUT - 1);

  state_e          state_q, state_d;
  logic [RowW-1:0] i_q, i_d;
  logic [ColW-1:0] j_q, j_d;
  logic            beat_q, first_q;
  logic signed [DATA_W-1:0] acc;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccum;
          i_d     = '0;
          j_d     = '0;
        end
      end
      StAccum: begin
        if (i_q == IMax) begin
          state_d = StDrain;
        end else begin
          i_d = i_q + RowW'(1);
        end
      end
      StDrain: state_d = StWrite;
      StWrite: begin
        if (a_ready) begin
          if (j_q == JMax) begin
            state_d = StDone;
          end else begin
            state_d = StAccum;
            j_d     = j_q + ColW'(1);
            i_d     = '0;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      beat_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      // Read data lags the address by one cycle; these flags travel with it.
      beat_q  <= rd_en;
      first_q <= rd_en && (i_q == '0);
    end
  end

  vmvmb_mac u_mac (
    .clk     (clk),
    .rst     (rst),
    .beat_i  (beat_q),
    .first_i (first_q),
    .x_i     (x_data),
    .h_i     (h_data),
    .wx_i    (wx_data),
    .wh_i    (wh_data),
    .b_i     (b_data),
    .acc_o   (acc)
  );

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign rd_en    = (state_q == StAccum);
  assign row_addr = i_q;
  assign col_addr = j_q;
  assign a_valid  = (state_q == StWrite);
  assign a_idx    = j_q;
  assign a_data   = acc;

endmodule

// File: tb/tb_vmvmb_seq.sv
// Bench for vmvmb_seq: a small fixed-vector instance plus a 4x3 instance checked by a scoreboard.
module tb_vmvmb_seq;
  import vmvmb_pkg::*;

  localparam int unsigned NI = 4;
  localparam int unsigned NO = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
    end
  endtask

  // Main instance
  logic rst, start, a_ready;
  logic busy, done, rd_en, a_valid;
  logic [1:0] row_addr, col_addr, a_idx;
  logic signed [31:0] x_data, h_data, wx_data, wh_data, b_data, a_data;

  logic signed [31:0] x_mem [NI];
  logic signed [31:0] h_mem [NI];
  logic signed [31:0] b_mem [NO];
  logic signed [31:0] wx_mem [NI][NO];
  logic signed [31:0] wh_mem [NI][NO];

  vmvmb_seq #(.N_IN(NI), .N_OUT(NO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .row_addr(row_addr), .col_addr(col_addr), .x_data(x_data), .h_data(h_data),
    .wx_data(wx_data), .wh_data(wh_data), .b_data(b_data), .a_valid(a_valid),
    .a_ready(a_ready), .a_idx(a_idx), .a_data(a_data)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      x_data  <= x_mem[row_addr];
      h_data  <= h_mem[row_addr];
      wx_data <= wx_mem[row_addr][col_addr];
      wh_data <= wh_mem[row_addr][col_addr];
      b_data  <= b_mem[col_addr];
    end
  end

  // Small instance for the hand-computed vector
  logic s_start, s_a_ready, s_busy, s_done, s_rd_en, s_a_valid;
  logic [0:0] s_row, s_col, s_a_idx;
  logic signed [31:0] s_x_data, s_h_data, s_wx_data, s_wh_data, s_b_data, s_a_data;
  logic signed [31:0] s_x [2];
  logic signed [31:0] s_h [2];
  logic signed [31:0] s_b [2];
  logic signed [31:0] s_wx [2][2];
  logic signed [31:0] s_wh [2][2];

  vmvmb_seq #(.N_IN(2), .N_OUT(1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done), .rd_en(s_rd_en),
    .row_addr(s_row), .col_addr(s_col), .x_data(s_x_data), .h_data(s_h_data),
    .wx_data(s_wx_data), .wh_data(s_wh_data), .b_data(s_b_data), .a_valid(s_a_valid),
    .a_ready(s_a_ready), .a_idx(s_a_idx), .a_data(s_a_data)
  );

  always @(posedge clk) begin
    if (s_rd_en) begin
      s_x_data  <= s_x[s_row];
      s_h_data  <= s_h[s_row];
      s_wx_data <= s_wx[s_row][s_col];
      s_wh_data <= s_wh[s_row][s_col];
      s_b_data  <= s_b[s_col];
    end
  end

  // Scoreboard
  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int c0 = 0;
  int done_cnt = 0;
  int done_rel = 0;

  function automatic logic [31:0] ref_a(input int j);
    logic [31:0] s;
    s = b_mem[j];
    for (int i = 0; i < int'(NI); i++) begin
      s = s + wx_mem[i][j] * x_mem[i] + wh_mem[i][j] * h_mem[i];
    end
    return s;
  endfunction

  task automatic push_pass(input int stall_j, input int stall_len);
    for (int j = 0; j < int'(NO); j++) begin
      exp_t e;
      e.idx  = 2'(j);
      e.data = ref_a(j);
      e.cyc  = (j + 1) * int'(NI + 2) + ((j >= stall_j) ? stall_len : 0);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid) begin
        check_eq("busy_in_write", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid", 32'(a_valid), 32'd0);
        end else begin
          check_eq("a_idx", 32'(a_idx), 32'(exp_q[0].idx));
          check_eq("a_data", a_data, exp_q[0].data);
          if (a_ready) begin
            check_eq("a_cycle", 32'(cyc - c0), 32'(exp_q[0].cyc));
            void'(exp_q.pop_front());
          end else begin
            check_eq("stall_rd_en", 32'(rd_en), 32'd0);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - c0;
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < int'(NI); i++) begin
      x_mem[i] = $urandom;
      h_mem[i] = $urandom;
      for (int j = 0; j < int'(NO); j++) begin
        wx_mem[i][j] = $urandom;
        wh_mem[i][j] = $urandom;
      end
    end
    for (int j = 0; j < int'(NO); j++) b_mem[j] = $urandom;
  endtask

  task automatic start_pass();
    @(posedge clk); #1;
    start = 1'b1;
    c0    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs until a done pulse or budget expiry; stall_rel opens a 3-cycle a_ready=0 window.
  task automatic wait_done(input int stall_rel, input int st1, input int st2, input int exp_done);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      a_ready = !((cyc - c0) >= stall_rel && (cyc - c0) < stall_rel + 3);
      start   = ((cyc - c0) == st1) || ((cyc - c0) == st2);
      if (done_cnt != d0) break;
    end
    start   = 1'b0;
    a_ready = 1'b1;
    check_eq("done_count", 32'(done_cnt - d0), 32'd1);
    check_eq("done_cycle", 32'(done_rel), 32'(exp_done));
    repeat (10) @(posedge clk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("no_extra_done", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_done"}, 32'(done), 32'd0);
    check_eq({pfx, "_rd_en"}, 32'(rd_en), 32'd0);
    check_eq({pfx, "_row"}, 32'(row_addr), 32'd0);
    check_eq({pfx, "_col"}, 32'(col_addr), 32'd0);
    check_eq({pfx, "_valid"}, 32'(a_valid), 32'd0);
    check_eq({pfx, "_idx"}, 32'(a_idx), 32'd0);
    check_eq({pfx, "_data"}, a_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got no end expected end");
    $fatal(1);
  end

  initial begin
    int s0;
    int d0;
    logic s_seen, s_dseen;
    rst = 1'b1; start = 1'b0; a_ready = 1'b1;
    s_start = 1'b0; s_a_ready = 1'b1;
    s_x = '{32'sd1, 32'sd2};
    s_h = '{32'sd3, 32'sd4};
    s_b = '{32'sd10, 32'sd0};
    s_wx = '{'{32'sd5, 32'sd0}, '{32'sd6, 32'sd0}};
    s_wh = '{'{32'sd7, 32'sd0}, '{32'sd8, 32'sd0}};
    fill_random();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Hand-computed vector: 5+12+21+32+10 = 80 at cycle 4, done at cycle 5
    @(posedge clk); #1;
    s_start = 1'b1;
    s0      = cyc;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_seen  = 1'b0;
    s_dseen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_a_valid && !s_seen) begin
        s_seen = 1'b1;
        check_eq("s_valid_cycle", 32'(cyc - s0), 32'd4);
        check_eq("s_a_data", s_a_data, 32'd80);
        check_eq("s_a_idx", 32'(s_a_idx), 32'd0);
        check_eq("s_busy", 32'(s_busy), 32'd1);
      end
      if (s_done && !s_dseen) begin
        s_dseen = 1'b1;
        check_eq("s_done_cycle", 32'(cyc - s0), 32'd5);
      end
    end
    check_eq("s_valid_seen", 32'(s_seen), 32'd1);
    check_eq("s_done_seen", 32'(s_dseen), 32'd1);

    // Random pass, no back-pressure
    fill_random();
    push_pass(99, 0);
    start_pass();
    wait_done(-10, -1, -1, 19);

    // Three-cycle stall on j=1
    fill_random();
    push_pass(1, 3);
    start_pass();
    wait_done(12, -1, -1, 22);

    // Product wrap: 0x4000_0000 * 4 truncates to 0
    for (int i = 0; i < int'(NI); i++) begin
      x_mem[i] = 0; h_mem[i] = 0;
      for (int j = 0; j < int'(NO); j++) begin
        wx_mem[i][j] = 0; wh_mem[i][j] = 0;
      end
    end
    for (int j = 0; j < int'(NO); j++) b_mem[j] = 0;
    wx_mem[0][0] = 32'sh4000_0000;
    x_mem[0]     = 32'sd4;
    b_mem[0]     = 32'sd1;
    h_mem[1]     = -32'sd3;
    wh_mem[1][2] = 32'sh7fff_ffff;
    push_pass(99, 0);
    start_pass();
    wait_done(-10, -1, -1, 19);

    // Reset in ACCUM of j=1 aborts the pass
    fill_random();
    push_pass(99, 0);
    start_pass();
    while ((cyc - c0) < 8) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    d0  = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("mid_rst");
    repeat (30) @(posedge clk);
    check_eq("rst_no_done", 32'(done_cnt - d0), 32'd0);
    push_pass(99, 0);
    start_pass();
    wait_done(-10, -1, -1, 19);

    // start pulses while busy and in DONE are ignored
    fill_random();
    push_pass(99, 0);
    start_pass();
    wait_done(-10, 3, 19, 19);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
